// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared 32-bit memory port.
// Instruction fetch (IF) and data memory (DM) compete for the port. A granted
// transfer holds the port until the memory acknowledges or the watchdog expires.
// mem_sel drives the external address/data muxes (0 = IF, 1 = DM).
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction fetch requester (read only)
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_grant,
    output logic        if_done,
    output logic [31:0] if_rdata,
    // data memory requester
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_grant,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    // shared memory port
    output logic        mem_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_dm;   // 1: DM won the most recent grant
    logic [CNT_W-1:0]   r_wd_cnt;    // BUSY cycles spent without mem_ready

    logic               w_pick_dm;
    logic               w_pick_if;
    logic               w_owner_dm;
    logic               w_wd_expired;

    // Arbitration: on a tie the requester that did not win last time is chosen.
    always_comb begin
        w_pick_dm    = dm_req & (~if_req | ~r_last_dm);
        w_pick_if    = if_req & ~w_pick_dm;
        w_owner_dm   = (r_state == S_BUSY_DM);
        w_wd_expired = (r_wd_cnt == CNT_W'(TIMEOUT - 1));
    end

    // Port sequencer: accepts one request in IDLE, then waits in BUSY for the
    // acknowledge or the watchdog; every output is a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_last_dm <= 1'b0;
            r_wd_cnt  <= '0;
            if_grant  <= 1'b0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            dm_grant  <= 1'b0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
            mem_sel   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            // pulses default low and are raised for exactly one cycle below
            if_grant <= 1'b0;
            dm_grant <= 1'b0;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // mem_ready is deliberately ignored here
                    if (w_pick_dm) begin
                        r_state   <= S_BUSY_DM;
                        r_last_dm <= 1'b1;
                        r_wd_cnt  <= '0;
                        dm_grant  <= 1'b1;
                        mem_sel   <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (w_pick_if) begin
                        r_state   <= S_BUSY_IF;
                        r_last_dm <= 1'b0;
                        r_wd_cnt  <= '0;
                        if_grant  <= 1'b1;
                        mem_sel   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                    end
                end

                S_BUSY_IF, S_BUSY_DM: begin
                    // an acknowledge on the last watchdog cycle still completes normally
                    if (mem_ready) begin
                        if (!mem_we) begin
                            if (w_owner_dm) dm_rdata <= mem_rdata;
                            else            if_rdata <= mem_rdata;
                        end
                        if (w_owner_dm) dm_done <= 1'b1;
                        else            if_done <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_wd_expired) begin
                        // abort: owner still gets its done so it never stalls, data untouched
                        err <= 1'b1;
                        if (w_owner_dm) dm_done <= 1'b1;
                        else            if_done <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_grant, if_done, dm_grant, dm_done;
    logic        mem_sel, mem_req, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_grant  (if_grant),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_grant  (dm_grant),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_sel   (mem_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    typedef struct {
        logic        dm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic sb_push(input logic dm, input logic [31:0] rdata, input logic e);
        exp_t x;
        x.dm = dm; x.rdata = rdata; x.err = e;
        sb.push_back(x);
    endtask

    // called on the cycle a completion is due
    task automatic sb_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, "_if_done"}, if_done, !x.dm);
            chk({tag, "_dm_done"}, dm_done, x.dm);
            chk({tag, "_err"}, err, x.err);
            chk({tag, "_mem_req"}, mem_req, 1'b0);
            chk({tag, "_rdata"}, x.dm ? dm_rdata : if_rdata, x.rdata);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_grant"}, if_grant, 0);
        chk({tag, "_dm_grant"}, dm_grant, 0);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_dm_done"}, dm_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_sel"}, mem_sel, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
    endtask

    initial begin
        reset_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk_zero("reset");
        reset_n = 1'b1;

        // IF alone, zero-wait memory
        if_req = 1; if_addr = 32'h0040_0000; mem_rdata = 32'h8C88_0004; mem_ready = 1;
        exp_if_rdata = 32'h8C88_0004;
        sb_push(1'b0, exp_if_rdata, 1'b0);
        tick();
        chk("if1_grant", if_grant, 1);
        chk("if1_sel", mem_sel, 0);
        chk("if1_req", mem_req, 1);
        chk("if1_we", mem_we, 0);
        chk("if1_addr", mem_addr, 32'h0040_0000);
        if_req = 0;
        tick();
        sb_check("if1");
        mem_ready = 0;
        tick();

        // four ties: alternate DM, IF, DM, IF
        for (int i = 0; i < 4; i++) begin
            logic        wdm;
            logic [31:0] rd;
            wdm = (i % 2 == 0);
            rd  = 32'hA000_0000 + 32'(i);
            if_req = 1; dm_req = 1; dm_we = 0;
            if_addr = 32'h0040_0100 + 32'(i * 4);
            dm_addr = 32'h1000_0000 + 32'(i * 4);
            mem_rdata = rd; mem_ready = 1;
            if (wdm) exp_dm_rdata = rd; else exp_if_rdata = rd;
            sb_push(wdm, rd, 1'b0);
            tick();
            chk($sformatf("tie%0d_dm_grant", i), dm_grant, wdm);
            chk($sformatf("tie%0d_if_grant", i), if_grant, !wdm);
            chk($sformatf("tie%0d_sel", i), mem_sel, wdm);
            chk($sformatf("tie%0d_addr", i), mem_addr, wdm ? dm_addr : if_addr);
            if_req = 0; dm_req = 0;
            tick();
            sb_check($sformatf("tie%0d", i));
            chk($sformatf("tie%0d_sel_hold", i), mem_sel, wdm);
        end
        mem_ready = 0;
        tick();

        // DM write with 3 wait states; ready lands on the last watchdog cycle
        dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        sb_push(1'b1, exp_dm_rdata, 1'b0);
        tick();
        chk("wr_grant", dm_grant, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_sel", mem_sel, 1);
        dm_req = 0; dm_we = 0; dm_addr = 32'hFFFF_FFFF; dm_wdata = 32'h0;
        if_req = 1;  // ignored while busy
        for (int w = 0; w < 3; w++) begin
            tick();
            chk($sformatf("wr_wait%0d_addr", w), mem_addr, 32'h1001_0000);
            chk($sformatf("wr_wait%0d_wdata", w), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("wr_wait%0d_we", w), mem_we, 1);
            chk($sformatf("wr_wait%0d_req", w), mem_req, 1);
            chk($sformatf("wr_wait%0d_done", w), dm_done | if_done | if_grant, 0);
        end
        if_req = 0;
        mem_ready = 1;
        tick();
        sb_check("wr");
        mem_ready = 0;
        tick();

        // watchdog abort on an IF read
        if_req = 1; if_addr = 32'h0040_0200; mem_rdata = 32'h1234_5678;
        sb_push(1'b0, exp_if_rdata, 1'b1);
        tick();
        chk("to_grant", if_grant, 1);
        if_req = 0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk($sformatf("to_wait%0d_err", w), err, 0);
            chk($sformatf("to_wait%0d_done", w), if_done, 0);
        end
        tick();
        sb_check("to");
        tick();
        chk("to_err_pulse", err, 0);

        // next request after abort is served normally
        if_req = 1; if_addr = 32'h0040_0204; mem_rdata = 32'h0BAD_F00D; mem_ready = 1;
        exp_if_rdata = 32'h0BAD_F00D;
        sb_push(1'b0, exp_if_rdata, 1'b0);
        tick();
        chk("post_to_grant", if_grant, 1);
        if_req = 0;
        tick();
        sb_check("post_to");
        mem_ready = 0;
        tick();

        // IF read acknowledged exactly on the watchdog cycle
        if_req = 1; if_addr = 32'h0040_0300; mem_rdata = 32'hCAFE_0001;
        exp_if_rdata = 32'hCAFE_0001;
        sb_push(1'b0, exp_if_rdata, 1'b0);
        tick();
        if_req = 0;
        tick(); tick(); tick();
        chk("edge_no_done", if_done, 0);
        mem_ready = 1;
        tick();
        sb_check("edge");
        mem_ready = 0;
        tick();

        // asynchronous reset during a DM wait
        dm_req = 1; dm_we = 0; dm_addr = 32'h1002_0000;
        tick();
        chk("rst_grant", dm_grant, 1);
        dm_req = 0;
        tick();
        chk("rst_busy_req", mem_req, 1);
        #3 reset_n = 1'b0;
        #1 chk_zero("async_rst");
        tick();
        chk_zero("rst_hold");
        reset_n = 1'b1;
        tick();
        chk("rst_no_done", if_done | dm_done | err, 0);

        // tie after reset goes to DM first
        if_req = 1; dm_req = 1; dm_we = 0; mem_rdata = 32'h7777_0000; mem_ready = 1;
        sb_push(1'b1, 32'h7777_0000, 1'b0);
        tick();
        chk("rst_tie_dm_grant", dm_grant, 1);
        chk("rst_tie_if_grant", if_grant, 0);
        chk("rst_tie_sel", mem_sel, 1);
        if_req = 0; dm_req = 0;
        tick();
        sb_check("rst_tie");
        mem_ready = 0;

        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
